// File: rtl/cr16_pkg.sv
// Shared types and encodings for the CR16 control sequencer.
package cr16_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_MEM     = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU   = 3'd0,
        CLS_LOAD  = 3'd1,
        CLS_STOR  = 3'd2,
        CLS_JAL   = 3'd3,
        CLS_JCOND = 3'd4,
        CLS_BCOND = 3'd5
    } class_e;

    // Major opcode IR[15:12] and extension IR[7:4]
    localparam logic [3:0] OP_MEMJMP = 4'b0100;
    localparam logic [3:0] OP_BCOND  = 4'b1100;
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    // Condition codes IR[11:8]
    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_HI = 4'b0100;
    localparam logic [3:0] CC_LS = 4'b0101;
    localparam logic [3:0] CC_GT = 4'b0110;
    localparam logic [3:0] CC_LE = 4'b0111;
    localparam logic [3:0] CC_FS = 4'b1000;
    localparam logic [3:0] CC_FC = 4'b1001;
    localparam logic [3:0] CC_LO = 4'b1010;
    localparam logic [3:0] CC_HS = 4'b1011;
    localparam logic [3:0] CC_LT = 4'b1100;
    localparam logic [3:0] CC_GE = 4'b1101;
    localparam logic [3:0] CC_UC = 4'b1110;

    // Flag bit positions within {C,L,F,Z,N}
    localparam int unsigned FLAG_C = 4;
    localparam int unsigned FLAG_L = 3;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 0;

    // Instruction class from opcode and extension fields
    function automatic class_e classify(input logic [3:0] op, input logic [3:0] ext);
        class_e cls;
        cls = CLS_ALU;
        if (op == OP_BCOND) begin
            cls = CLS_BCOND;
        end else if (op == OP_MEMJMP) begin
            case (ext)
                EXT_LOAD:  cls = CLS_LOAD;
                EXT_STOR:  cls = CLS_STOR;
                EXT_JAL:   cls = CLS_JAL;
                EXT_JCOND: cls = CLS_JCOND;
                default:   cls = CLS_ALU;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator: condition code against PSR flags.
module cond_eval
    import cr16_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [4:0] flags_i,
    output logic       taken_o
);

    logic c, l, f, z, n;

    assign c = flags_i[FLAG_C];
    assign l = flags_i[FLAG_L];
    assign f = flags_i[FLAG_F];
    assign z = flags_i[FLAG_Z];
    assign n = flags_i[FLAG_N];

    // Condition decode; 1111 is the never-taken code
    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            CC_EQ:   taken_o = z;
            CC_NE:   taken_o = ~z;
            CC_CS:   taken_o = c;
            CC_CC:   taken_o = ~c;
            CC_HI:   taken_o = l;
            CC_LS:   taken_o = ~l;
            CC_GT:   taken_o = n;
            CC_LE:   taken_o = ~n;
            CC_FS:   taken_o = f;
            CC_FC:   taken_o = ~f;
            CC_LO:   taken_o = ~l & ~z;
            CC_HS:   taken_o = l | z;
            CC_LT:   taken_o = ~n & ~z;
            CC_GE:   taken_o = n | z;
            CC_UC:   taken_o = 1'b1;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// CR16 multi-cycle sequencer: fetch, decode, execute, memory phases.
module control_fsm
    import cr16_pkg::*;
#(
    parameter int unsigned P_ADDRESS_WIDTH = 16,
    parameter int unsigned P_DATA_WIDTH    = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [P_DATA_WIDTH-1:0]    instruction_i,
    input  logic [P_DATA_WIDTH-1:0]    ir_i,
    input  logic [4:0]                 flags_i,
    input  logic [P_ADDRESS_WIDTH-1:0] rtarget_i,
    input  logic                       mem_ack_i,
    output logic                       mem_read_o,
    output logic                       mem_write_o,
    output logic                       mem_addr_select_o,
    output logic                       ir_load_o,
    output logic                       regfile_we_o,
    output logic                       link_we_o,
    output logic                       pc_enable_o,
    output logic                       pc_address_select_o,
    output logic                       pc_address_select_increment_o,
    output logic                       pc_address_select_displace_o,
    output logic [P_ADDRESS_WIDTH-1:0] pc_address_o,
    output logic [1:0]                 state_o
);

    localparam int unsigned AW = P_ADDRESS_WIDTH;

    state_e          state_q, state_d;
    class_e          cls_q, cls_d;
    logic            taken_q, taken_d;
    logic [AW-1:0]   target_q, target_d;
    logic            cond_taken;

    logic            mem_read_c, mem_write_c, mem_addr_sel_c, ir_load_c;
    logic            regfile_we_c, link_we_c, pc_enable_c, pc_sel_c, pc_disp_c;
    logic [AW-1:0]   pc_addr_c;

    // Instruction word is captured by the datapath; only its IR copy is decoded here
    logic [P_DATA_WIDTH-1:0] unused_instruction;
    assign unused_instruction = instruction_i;

    cond_eval u_cond_eval (
        .cond_i  (ir_i[11:8]),
        .flags_i (flags_i),
        .taken_o (cond_taken)
    );

    // State and decoded-instruction registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_FETCH;
            cls_q    <= CLS_ALU;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            taken_q  <= taken_d;
            target_q <= target_d;
        end
    end

    // Next-state and control decode from state, latched class and memory handshake
    always_comb begin
        state_d        = state_q;
        cls_d          = cls_q;
        taken_d        = taken_q;
        target_d       = target_q;
        mem_read_c     = 1'b0;
        mem_write_c    = 1'b0;
        mem_addr_sel_c = 1'b0;
        ir_load_c      = 1'b0;
        regfile_we_c   = 1'b0;
        link_we_c      = 1'b0;
        pc_enable_c    = 1'b0;
        pc_sel_c       = 1'b0;
        pc_disp_c      = 1'b0;
        pc_addr_c      = '0;

        case (state_q)
            ST_FETCH: begin
                mem_read_c = 1'b1;
                if (mem_ack_i) begin
                    ir_load_c = 1'b1;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Branch target and condition are resolved here so EXECUTE is register-driven
                cls_d   = classify(ir_i[15:12], ir_i[7:4]);
                taken_d = (cls_d == CLS_JAL) | cond_taken;
                if (cls_d == CLS_BCOND) begin
                    target_d = {{(AW-8){ir_i[7]}}, ir_i[7:0]};
                end else begin
                    target_d = rtarget_i;
                end
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                state_d = ST_FETCH;
                case (cls_q)
                    CLS_ALU: begin
                        regfile_we_c = 1'b1;
                        pc_enable_c  = 1'b1;
                    end
                    CLS_BCOND: begin
                        pc_enable_c = 1'b1;
                        if (taken_q) begin
                            pc_sel_c  = 1'b1;
                            pc_disp_c = 1'b1;
                            pc_addr_c = target_q;
                        end
                    end
                    CLS_JCOND: begin
                        pc_enable_c = 1'b1;
                        if (taken_q) begin
                            pc_sel_c  = 1'b1;
                            pc_addr_c = target_q;
                        end
                    end
                    CLS_JAL: begin
                        link_we_c   = 1'b1;
                        pc_enable_c = 1'b1;
                        pc_sel_c    = 1'b1;
                        pc_addr_c   = target_q;
                    end
                    CLS_LOAD, CLS_STOR: begin
                        state_d = ST_MEM;
                    end
                    default: begin
                        regfile_we_c = 1'b1;
                        pc_enable_c  = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                mem_addr_sel_c = 1'b1;
                mem_read_c     = (cls_q == CLS_LOAD);
                mem_write_c    = (cls_q == CLS_STOR);
                if (mem_ack_i) begin
                    regfile_we_c = (cls_q == CLS_LOAD);
                    pc_enable_c  = 1'b1;
                    state_d      = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Reset silences every strobe immediately, abandoning any access in flight
    assign mem_read_o                    = mem_read_c     & ~reset_i;
    assign mem_write_o                   = mem_write_c    & ~reset_i;
    assign mem_addr_select_o             = mem_addr_sel_c & ~reset_i;
    assign ir_load_o                     = ir_load_c      & ~reset_i;
    assign regfile_we_o                  = regfile_we_c   & ~reset_i;
    assign link_we_o                     = link_we_c      & ~reset_i;
    assign pc_enable_o                   = pc_enable_c    & ~reset_i;
    assign pc_address_select_o           = pc_sel_c       & ~reset_i;
    assign pc_address_select_displace_o  = pc_disp_c      & ~reset_i;
    assign pc_address_select_increment_o = 1'b0;
    assign pc_address_o                  = reset_i ? '0 : pc_addr_c;
    assign state_o                       = 2'(state_q);

endmodule

// File: tb/tb_control_fsm.sv
// Directed and randomized checks for the CR16 control sequencer.
module tb_control_fsm;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [15:0] instruction_i;
    logic [15:0] ir_i;
    logic [4:0]  flags_i;
    logic [15:0] rtarget_i;
    logic        mem_ack_i;
    logic        mem_read_o, mem_write_o, mem_addr_select_o, ir_load_o;
    logic        regfile_we_o, link_we_o, pc_enable_o;
    logic        pc_address_select_o, pc_address_select_increment_o, pc_address_select_displace_o;
    logic [15:0] pc_address_o;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    control_fsm #(.P_ADDRESS_WIDTH(16), .P_DATA_WIDTH(16)) dut (
        .clk_i                         (clk_i),
        .reset_i                       (reset_i),
        .instruction_i                 (instruction_i),
        .ir_i                          (ir_i),
        .flags_i                       (flags_i),
        .rtarget_i                     (rtarget_i),
        .mem_ack_i                     (mem_ack_i),
        .mem_read_o                    (mem_read_o),
        .mem_write_o                   (mem_write_o),
        .mem_addr_select_o             (mem_addr_select_o),
        .ir_load_o                     (ir_load_o),
        .regfile_we_o                  (regfile_we_o),
        .link_we_o                     (link_we_o),
        .pc_enable_o                   (pc_enable_o),
        .pc_address_select_o           (pc_address_select_o),
        .pc_address_select_increment_o (pc_address_select_increment_o),
        .pc_address_select_displace_o  (pc_address_select_displace_o),
        .pc_address_o                  (pc_address_o),
        .state_o                       (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Fetch with immediate ACK, pass DECODE, return at start of the EXECUTE cycle
    task automatic fetch_decode(input logic [15:0] instr, input logic [4:0] flags);
        instruction_i = instr;
        ir_i          = instr;
        flags_i       = flags;
        mem_ack_i     = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_i = 1'b1; mem_ack_i = 1'b0; instruction_i = '0; ir_i = '0;
        flags_i = '0; rtarget_i = '0;
        repeat (3) tick();
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
        checks++; if (mem_read_o !== 1'b0) begin errors++; $display("FAIL reset_read got %b want 0", mem_read_o); end
        checks++; if (pc_address_o !== 16'h0) begin errors++; $display("FAIL reset_pcaddr got %h want 0000", pc_address_o); end
        reset_i = 1'b0;
        tick();
        #1;
        checks++; if (mem_read_o !== 1'b1 || state_o !== 2'd0) begin errors++; $display("FAIL fetch_after_reset read=%b state=%0d want 1/0", mem_read_o, state_o); end
        mem_ack_i = 1'b1;
        reset_i   = 1'b1;
        #1;
        checks++; if (state_o !== 2'd0 || mem_read_o !== 1'b0 || ir_load_o !== 1'b0) begin
            errors++; $display("FAIL reset_mid_fetch state=%0d read=%b irload=%b want 0/0/0", state_o, mem_read_o, ir_load_o);
        end
        tick();
        mem_ack_i = 1'b0;
        reset_i   = 1'b0;
        tick();
        #1;
        checks++; if (state_o !== 2'd0 || mem_read_o !== 1'b1 || mem_addr_select_o !== 1'b0) begin
            errors++; $display("FAIL refetch state=%0d read=%b asel=%b want 0/1/0", state_o, mem_read_o, mem_addr_select_o);
        end
        tick();
    endtask

    task automatic test_alu();
        instruction_i = 16'h0512; ir_i = 16'h0512; flags_i = '0; mem_ack_i = 1'b1;
        #1;
        checks++; if (state_o !== 2'd0 || ir_load_o !== 1'b1 || mem_read_o !== 1'b1) begin
            errors++; $display("FAIL alu_fetch state=%0d irload=%b read=%b want 0/1/1", state_o, ir_load_o, mem_read_o);
        end
        tick();
        #1;
        checks++; if (state_o !== 2'd1 || ir_load_o !== 1'b0 || pc_enable_o !== 1'b0 || mem_read_o !== 1'b0) begin
            errors++; $display("FAIL alu_decode state=%0d irload=%b pcen=%b read=%b want 1/0/0/0", state_o, ir_load_o, pc_enable_o, mem_read_o);
        end
        tick();
        #1;
        checks++; if (state_o !== 2'd2 || regfile_we_o !== 1'b1 || pc_enable_o !== 1'b1 || pc_address_select_o !== 1'b0) begin
            errors++; $display("FAIL alu_exec state=%0d we=%b pcen=%b sel=%b want 2/1/1/0", state_o, regfile_we_o, pc_enable_o, pc_address_select_o);
        end
        checks++; if (pc_address_select_increment_o !== 1'b0) begin errors++; $display("FAIL alu_incr got %b want 0", pc_address_select_increment_o); end
        tick();
        mem_ack_i = 1'b0;
        #1;
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL alu_return got %0d want 0", state_o); end
    endtask

    task automatic test_bcond();
        fetch_decode(16'hC0FE, 5'b00010);
        #1;
        checks++; if (pc_enable_o !== 1'b1 || pc_address_select_o !== 1'b1 || pc_address_select_displace_o !== 1'b1 || pc_address_o !== 16'hFFFE) begin
            errors++; $display("FAIL beq_taken en=%b sel=%b disp=%b addr=%h want 1/1/1/fffe", pc_enable_o, pc_address_select_o, pc_address_select_displace_o, pc_address_o);
        end
        tick();
        fetch_decode(16'hC0FE, 5'b00000);
        #1;
        checks++; if (pc_enable_o !== 1'b1 || pc_address_select_o !== 1'b0 || pc_address_select_displace_o !== 1'b0 || pc_address_o !== 16'h0000) begin
            errors++; $display("FAIL beq_not_taken en=%b sel=%b disp=%b addr=%h want 1/0/0/0000", pc_enable_o, pc_address_select_o, pc_address_select_displace_o, pc_address_o);
        end
        tick();
        fetch_decode(16'hCA05, 5'b00000);
        #1;
        checks++; if (pc_address_select_o !== 1'b1 || pc_address_o !== 16'h0005) begin
            errors++; $display("FAIL blo_taken sel=%b addr=%h want 1/0005", pc_address_select_o, pc_address_o);
        end
        tick();
        fetch_decode(16'hCD05, 5'b00000);
        #1;
        checks++; if (pc_enable_o !== 1'b1 || pc_address_select_o !== 1'b0) begin
            errors++; $display("FAIL bge_not_taken en=%b sel=%b want 1/0", pc_enable_o, pc_address_select_o);
        end
        tick();
    endtask

    task automatic test_jumps();
        rtarget_i = 16'h0040;
        fetch_decode(16'h4E8A, 5'b00000);
        #1;
        checks++; if (link_we_o !== 1'b1 || pc_enable_o !== 1'b1 || pc_address_select_o !== 1'b1 || pc_address_o !== 16'h0040 || regfile_we_o !== 1'b0) begin
            errors++; $display("FAIL jal link=%b en=%b sel=%b addr=%h we=%b want 1/1/1/0040/0", link_we_o, pc_enable_o, pc_address_select_o, pc_address_o, regfile_we_o);
        end
        tick();
        rtarget_i = 16'h1234;
        fetch_decode(16'h4ECA, 5'b00000);
        #1;
        checks++; if (pc_address_select_o !== 1'b1 || pc_address_o !== 16'h1234 || pc_address_select_displace_o !== 1'b0 || link_we_o !== 1'b0) begin
            errors++; $display("FAIL juc sel=%b addr=%h disp=%b link=%b want 1/1234/0/0", pc_address_select_o, pc_address_o, pc_address_select_displace_o, link_we_o);
        end
        tick();
        fetch_decode(16'h4FCA, 5'b11111);
        #1;
        checks++; if (pc_enable_o !== 1'b1 || pc_address_select_o !== 1'b0 || pc_address_o !== 16'h0000) begin
            errors++; $display("FAIL jnever en=%b sel=%b addr=%h want 1/0/0000", pc_enable_o, pc_address_select_o, pc_address_o);
        end
        tick();
    endtask

    task automatic test_load_wait();
        fetch_decode(16'h4201, 5'b00000);
        #1;
        checks++; if (state_o !== 2'd2 || pc_enable_o !== 1'b0 || mem_read_o !== 1'b0) begin
            errors++; $display("FAIL load_exec state=%0d en=%b read=%b want 2/0/0", state_o, pc_enable_o, mem_read_o);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            mem_ack_i = 1'b0;
            #1;
            checks++; if (state_o !== 2'd3 || mem_read_o !== 1'b1 || mem_write_o !== 1'b0 || mem_addr_select_o !== 1'b1 || pc_enable_o !== 1'b0 || regfile_we_o !== 1'b0) begin
                errors++; $display("FAIL load_wait%0d state=%0d rd=%b wr=%b asel=%b en=%b we=%b want 3/1/0/1/0/0", i, state_o, mem_read_o, mem_write_o, mem_addr_select_o, pc_enable_o, regfile_we_o);
            end
            tick();
        end
        mem_ack_i = 1'b1;
        #1;
        checks++; if (regfile_we_o !== 1'b1 || pc_enable_o !== 1'b1 || pc_address_select_o !== 1'b0 || mem_read_o !== 1'b1) begin
            errors++; $display("FAIL load_ack we=%b en=%b sel=%b rd=%b want 1/1/0/1", regfile_we_o, pc_enable_o, pc_address_select_o, mem_read_o);
        end
        tick();
        mem_ack_i = 1'b0;
        #1;
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL load_return got %0d want 0", state_o); end
        tick();
    endtask

    task automatic test_store();
        fetch_decode(16'h4241, 5'b00000);
        tick();
        mem_ack_i = 1'b1;
        #1;
        checks++; if (mem_write_o !== 1'b1 || mem_read_o !== 1'b0 || regfile_we_o !== 1'b0 || pc_enable_o !== 1'b1 || mem_addr_select_o !== 1'b1) begin
            errors++; $display("FAIL stor_ack wr=%b rd=%b we=%b en=%b asel=%b want 1/0/0/1/1", mem_write_o, mem_read_o, regfile_we_o, pc_enable_o, mem_addr_select_o);
        end
        tick();
        mem_ack_i = 1'b0;
    endtask

    task automatic test_reset_mid_mem();
        fetch_decode(16'h4201, 5'b00000);
        tick();
        mem_ack_i = 1'b0;
        #1;
        checks++; if (state_o !== 2'd3 || mem_read_o !== 1'b1) begin
            errors++; $display("FAIL mem_before_reset state=%0d rd=%b want 3/1", state_o, mem_read_o);
        end
        tick();
        mem_ack_i = 1'b1;
        reset_i   = 1'b1;
        #1;
        checks++; if (pc_enable_o !== 1'b0 || regfile_we_o !== 1'b0 || mem_read_o !== 1'b0 || state_o !== 2'd0) begin
            errors++; $display("FAIL reset_mid_mem en=%b we=%b rd=%b state=%0d want 0/0/0/0", pc_enable_o, regfile_we_o, mem_read_o, state_o);
        end
        tick();
        mem_ack_i = 1'b0;
        reset_i   = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [15:0] instr;
        int          pulses;
        bit          left_fetch;
        bit          done;
        int          sel;
        pulses = 0;
        for (int n = 0; n < 1000; n++) begin
            instr = 16'($urandom);
            sel   = int'($urandom_range(0, 3));
            if (sel == 0) begin
                instr[15:12] = 4'b0100;
                instr[7:6]   = 2'($urandom);
                instr[5:4]   = 2'b00;
            end else if (sel == 1) begin
                instr[15:12] = 4'b1100;
            end
            instruction_i = instr;
            ir_i          = instr;
            flags_i       = 5'($urandom);
            rtarget_i     = 16'($urandom);
            left_fetch    = 1'b0;
            done          = 1'b0;
            for (int cyc = 0; cyc < 60 && !done; cyc++) begin
                mem_ack_i = 1'($urandom_range(0, 1));
                #1;
                checks++; if (mem_read_o === 1'b1 && mem_write_o === 1'b1) begin
                    errors++; $display("FAIL rw_exclusive instr=%h got both high want not both", instr);
                end
                if (pc_enable_o === 1'b1) pulses++;
                tick();
                if (state_o !== 2'd0) left_fetch = 1'b1;
                else if (left_fetch) done = 1'b1;
            end
            checks++; if (!done) begin
                errors++; $display("FAIL random_timeout instr=%h state=%0d want return to 0", instr, state_o);
            end
        end
        mem_ack_i = 1'b0;
        checks++; if (pulses != 1000) begin
            errors++; $display("FAIL pc_enable_count got %0d want 1000", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_bcond();
        test_jumps();
        test_load_wait();
        test_store();
        test_reset_mid_mem();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
